// File: rtl/sdram_rd_buf.sv
// SDRAM read-data capture FIFO with a registered valid/ready output stage.
// Optional sticky overflow flag: define SDRAM_RD_BUF_OVF_EN to enable it.
module sdram_rd_buf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              sclk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              empty,
   input  logic              ovf_clr,
   output logic              overflow
);

   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

   logic [DATA_W:0]   r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [ADDR_W:0]   r_level;
   logic              r_full;
   logic              r_empty;
   out_state_t        r_state;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;

   logic              w_push;
   logic              w_pop;
   logic [ADDR_W:0]   w_level_nxt;

   // The read burst cannot stall, so a word arriving while full is simply lost.
   assign w_push = in_valid && !r_full;
   assign w_pop  = !r_empty && ((r_state == OUT_EMPTY) || out_ready);

   always_comb begin
      w_level_nxt = r_level;
      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + (ADDR_W+1)'(1);
         2'b01:   w_level_nxt = r_level - (ADDR_W+1)'(1);
         default: w_level_nxt = r_level;
      endcase
   end

   // NOTE: storage has no reset; the pointers alone define what is valid,
   // and leaving the array unreset lets it map onto plain RAM.
   always_ff @(posedge sclk) begin
      if (w_push) r_mem[r_wptr] <= {in_last, in_data};
   end

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wptr <= r_wptr + ADDR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + ADDR_W'(1);
         r_level <= w_level_nxt;
         r_full  <= (w_level_nxt == LVL_FULL);
         r_empty <= (w_level_nxt == '0);
      end
   end

   // Output stage: every word is loaded from memory, never bypassed.
   always_ff @(posedge sclk or posedge reset) begin
      if (reset) begin
         r_state    <= OUT_EMPTY;
         r_out_data <= '0;
         r_out_last <= 1'b0;
      end else begin
         case (r_state)
            OUT_EMPTY: begin
               if (!r_empty) begin
                  {r_out_last, r_out_data} <= r_mem[r_rptr];
                  r_state                  <= OUT_FULL;
               end
            end
            OUT_FULL: begin
               if (out_ready) begin
                  if (!r_empty) {r_out_last, r_out_data} <= r_mem[r_rptr];
                  else          r_state                  <= OUT_EMPTY;
               end
            end
            default: r_state <= OUT_EMPTY;
         endcase
      end
   end

   assign out_valid = (r_state == OUT_FULL);
   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign level     = r_level;
   assign full      = r_full;
   assign empty     = r_empty;

`ifdef SDRAM_RD_BUF_OVF_EN
   logic r_overflow;

   // A fresh drop outranks a clear so no loss event is ever hidden.
   always_ff @(posedge sclk or posedge reset) begin
      if (reset)                   r_overflow <= 1'b0;
      else if (in_valid && r_full) r_overflow <= 1'b1;
      else if (ovf_clr)            r_overflow <= 1'b0;
   end

   assign overflow = r_overflow;
`else
   logic w_unused_ovf_clr;

   assign w_unused_ovf_clr = ovf_clr;
   assign overflow         = 1'b0;
`endif

endmodule
